// File: rtl/seq_pkg.sv
// Shared types for the multi-phase sequencer: run modes, FSM states and mode decode.
package seq_pkg;

    typedef enum logic [1:0] {
        FREE_RUN  = 2'b00,
        ONE_SHOT  = 2'b01,
        PING_PONG = 2'b10,
        RSVD      = 2'b11
    } seq_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

    // The reserved encoding behaves as FREE_RUN, so it is folded away at latch time.
    function automatic seq_mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return ONE_SHOT;
            2'b10:   return PING_PONG;
            default: return FREE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/seq_phase_step.sv
// Combinational next-phase/direction computation applied on each dwell expiry.
module seq_phase_step
    import seq_pkg::*;
#(
    parameter  int NUM_PHASES = 4,
    localparam int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic [PH_W-1:0] phase,
    input  logic            dir,
    input  logic [1:0]      mode_q,
    output logic [PH_W-1:0] phase_nxt,
    output logic            dir_nxt,
    output logic            at_end,
    output logic            wrap_nxt
);

    localparam logic [PH_W-1:0] LAST = PH_W'(NUM_PHASES - 1);

    always_comb begin
        phase_nxt = phase;
        dir_nxt   = dir;
        at_end    = 1'b0;
        wrap_nxt  = 1'b0;
        case (seq_mode_t'(mode_q))
            ONE_SHOT: begin
                if (phase == LAST) begin
                    at_end = 1'b1;
                end else begin
                    phase_nxt = phase + PH_W'(1);
                end
            end
            PING_PONG: begin
                // Direction flips on arriving at an end, so each end phase is visited once.
                phase_nxt = dir ? phase + PH_W'(1) : phase - PH_W'(1);
                if (phase_nxt == LAST) begin
                    dir_nxt = 1'b0;
                end
                if (phase_nxt == '0) begin
                    dir_nxt  = 1'b1;
                    wrap_nxt = 1'b1;
                end
            end
            default: begin
                if (phase == LAST) begin
                    phase_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    phase_nxt = phase + PH_W'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/multi_phase_sequencer.sv
// Phase sequencer: steps through NUM_PHASES phases with a programmable dwell per phase.
module multi_phase_sequencer
    import seq_pkg::*;
#(
    parameter  int NUM_PHASES = 4,
    parameter  int CNT_W      = 8,
    localparam int PH_W       = $clog2(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [CNT_W-1:0]      dwell,
    output logic [PH_W-1:0]       phase,
    output logic [NUM_PHASES-1:0] phase_onehot,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);

    seq_state_t            state_q, state_d;
    seq_mode_t             mode_q, mode_d;
    logic [CNT_W-1:0]      dwell_q, dwell_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [NUM_PHASES-1:0] onehot_q, onehot_d;
    logic                  dir_q, dir_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wrap_q, wrap_d;

    logic [PH_W-1:0]       step_phase;
    logic                  step_dir;
    logic                  step_at_end;
    logic                  step_wrap;

    seq_phase_step #(
        .NUM_PHASES(NUM_PHASES)
    ) u_step (
        .phase     (phase_q),
        .dir       (dir_q),
        .mode_q    (mode_q),
        .phase_nxt (step_phase),
        .dir_nxt   (step_dir),
        .at_end    (step_at_end),
        .wrap_nxt  (step_wrap)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;

        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = '0;
            dir_d   = 1'b1;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d = RUN;
            mode_d  = decode_mode(mode);
            dwell_d = dwell;
            cnt_d   = '0;
            phase_d = '0;
            dir_d   = 1'b1;
            busy_d  = 1'b1;
        end else if (state_q == RUN && en) begin
            if (cnt_q != dwell_q) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
                if (step_at_end) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    phase_d = step_phase;
                    dir_d   = step_dir;
                    wrap_d  = step_wrap;
                end
            end
        end

        // One-hot is derived from the next phase so both update on the same edge.
        onehot_d = NUM_PHASES'(1) << phase_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= FREE_RUN;
            dwell_q  <= '0;
            cnt_q    <= '0;
            phase_q  <= '0;
            onehot_q <= NUM_PHASES'(1);
            dir_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            dwell_q  <= dwell_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            onehot_q <= onehot_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    assign phase        = phase_q;
    assign phase_onehot = onehot_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign wrap         = wrap_q;

endmodule

// File: tb/tb_multi_phase_sequencer.sv
// Bench for multi_phase_sequencer: directed literal checks plus randomized run against a step-count model.
module tb_multi_phase_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       en;
    logic [1:0] mode;
    logic [7:0] dwell;

    logic [1:0] ph4;
    logic [3:0] oh4;
    logic       busy4, done4, wrap4;
    logic       ph2;
    logic [1:0] oh2;
    logic       busy2, done2, wrap2;

    int n_err = 0;
    int n_chk = 0;

    multi_phase_sequencer #(.NUM_PHASES(4), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
        .mode(mode), .dwell(dwell),
        .phase(ph4), .phase_onehot(oh4), .busy(busy4), .done(done4), .wrap(wrap4)
    );

    multi_phase_sequencer #(.NUM_PHASES(2), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
        .mode(mode), .dwell(dwell),
        .phase(ph2), .phase_onehot(oh2), .busy(busy2), .done(done2), .wrap(wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a run is described by the number of phase steps taken (k) and ticks into the dwell.
    int m_n[2] = '{4, 2};
    int m_st[2];
    int m_k[2];
    int m_tk[2];
    int m_md[2];
    int m_dw[2];
    int m_done[2];
    int m_wrap[2];

    function automatic int ph_of(int n, int md, int st, int k);
        int p;
        if (st == 0) return 0;
        if (st == 2) return n - 1;
        if (md == 2) begin
            p = k % (2 * n - 2);
            return (p < n) ? p : (2 * n - 2 - p);
        end
        if (md == 1) return k;
        return k % n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_k[i] = 0; m_tk[i] = 0;
            m_done[i] = 0; m_wrap[i] = 0;
        end
    endtask

    task automatic m_step();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 0;
            m_wrap[i] = 0;
            if (stop) begin
                m_st[i] = 0; m_k[i] = 0; m_tk[i] = 0;
            end else if (start) begin
                m_st[i] = 1; m_k[i] = 0; m_tk[i] = 0;
                m_md[i] = (mode == 2'd3) ? 0 : int'(mode);
                m_dw[i] = int'(dwell);
            end else if (m_st[i] == 1 && en) begin
                if (m_tk[i] < m_dw[i]) begin
                    m_tk[i]++;
                end else begin
                    m_tk[i] = 0;
                    if (m_md[i] == 1 && m_k[i] == m_n[i] - 1) begin
                        m_st[i] = 2;
                        m_done[i] = 1;
                    end else begin
                        m_k[i]++;
                        if (m_md[i] != 1 && ph_of(m_n[i], m_md[i], 1, m_k[i]) == 0) m_wrap[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        int a_ph[2], a_oh[2], a_busy[2], a_done[2], a_wrap[2];
        int p;
        a_ph[0] = int'(ph4); a_oh[0] = int'(oh4); a_busy[0] = int'(busy4);
        a_done[0] = int'(done4); a_wrap[0] = int'(wrap4);
        a_ph[1] = int'(ph2); a_oh[1] = int'(oh2); a_busy[1] = int'(busy2);
        a_done[1] = int'(done2); a_wrap[1] = int'(wrap2);
        for (int i = 0; i < 2; i++) begin
            p = ph_of(m_n[i], m_md[i], m_st[i], m_k[i]);
            chk($sformatf("model_phase_n%0d", m_n[i]), a_ph[i], p);
            chk($sformatf("model_onehot_n%0d", m_n[i]), a_oh[i], 1 << p);
            chk($sformatf("model_busy_n%0d", m_n[i]), a_busy[i], (m_st[i] == 1) ? 1 : 0);
            chk($sformatf("model_done_n%0d", m_n[i]), a_done[i], m_done[i]);
            chk($sformatf("model_wrap_n%0d", m_n[i]), a_wrap[i], m_wrap[i]);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_step();
            #1;
            if (!rst) compare();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phase4"}, int'(ph4), 0);
        chk({tag, "_onehot4"}, int'(oh4), 1);
        chk({tag, "_busy4"}, int'(busy4), 0);
        chk({tag, "_done4"}, int'(done4), 0);
        chk({tag, "_wrap4"}, int'(wrap4), 0);
        chk({tag, "_phase2"}, int'(ph2), 0);
        chk({tag, "_onehot2"}, int'(oh2), 1);
    endtask

    // Reset is raised and dropped between clock edges to exercise the asynchronous path.
    task automatic reset_mid(input string tag);
        @(posedge clk);
        #4;
        rst = 1'b1;
        m_reset();
        #1;
        chk_reset_vals(tag);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] md, input logic [7:0] dw);
        mode = md; dwell = dw; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    int exp_t1[9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int exp_t3a[13] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
    int exp_t3b[13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b1; mode = 2'd0; dwell = 8'd0;
        m_reset();
        #12;
        chk_reset_vals("por");
        rst = 1'b0;
        cyc();

        // Free-run, dwell 1: each phase held two cycles, wrap on re-entering 0.
        do_start(2'd0, 8'd1);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) cyc();
            chk("t1_phase", int'(ph4), exp_t1[i]);
            chk("t1_wrap", int'(wrap4), (i == 8) ? 1 : 0);
            chk("t1_busy", int'(busy4), 1);
        end

        // One-shot, dwell 0.
        do_start(2'd1, 8'd0);
        chk("t2_phase0", int'(ph4), 0);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk("t2_phase", int'(ph4), i);
            chk("t2_busy", int'(busy4), 1);
            chk("t2_done_low", int'(done4), 0);
        end
        cyc();
        chk("t2_done_pulse", int'(done4), 1);
        chk("t2_busy_off", int'(busy4), 0);
        chk("t2_phase_held", int'(ph4), 3);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("t2_hold_phase", int'(ph4), 3);
            chk("t2_hold_done", int'(done4), 0);
            chk("t2_hold_busy", int'(busy4), 0);
        end

        // Ping-pong, dwell 0, on both phase counts.
        do_start(2'd2, 8'd0);
        for (int i = 0; i < 13; i++) begin
            if (i > 0) cyc();
            chk("t3_phase4", int'(ph4), exp_t3a[i]);
            chk("t3_wrap4", int'(wrap4), (i == 6 || i == 12) ? 1 : 0);
            chk("t3_phase2", int'(ph2), exp_t3b[i]);
            chk("t3_wrap2", int'(wrap2), (i > 0 && exp_t3b[i] == 0) ? 1 : 0);
        end

        // en toggling with dwell 2; mode/dwell inputs disturbed mid-run.
        do_start(2'd0, 8'd2);
        mode = 2'd1; dwell = 8'd7;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) begin
                en = (i % 2 == 1);
                cyc();
            end
            chk("t4_phase", int'(ph4), ((i + 1) / 6) % 4);
            chk("t4_wrap", int'(wrap4), (i == 23) ? 1 : 0);
        end
        en = 1'b1;

        // start+stop together during RUN: stop wins.
        do_start(2'd0, 8'd0);
        cyc();
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("t5_stop_phase", int'(ph4), 0);
        chk("t5_stop_busy", int'(busy4), 0);
        chk("t5_stop_onehot", int'(oh4), 1);

        // Restart on the expiry that would wrap.
        do_start(2'd0, 8'd0);
        cyc(); cyc(); cyc();
        chk("t5_pre_phase", int'(ph4), 3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t5_rs_phase", int'(ph4), 0);
        chk("t5_rs_wrap", int'(wrap4), 0);
        chk("t5_rs_busy", int'(busy4), 1);

        // Restart on the expiry that would complete a one-shot.
        do_start(2'd1, 8'd0);
        cyc(); cyc(); cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t5_os_phase", int'(ph4), 0);
        chk("t5_os_done", int'(done4), 0);
        chk("t5_os_busy", int'(busy4), 1);

        // Asynchronous reset mid-run, then restart.
        do_start(2'd0, 8'd1);
        for (int i = 0; i < 5; i++) cyc();
        chk("t6_pre_busy", int'(busy4), 1);
        reset_mid("t6");
        cyc();
        chk("t6_idle_busy", int'(busy4), 0);
        do_start(2'd2, 8'd0);
        chk("t6_rs_busy", int'(busy4), 1);
        chk("t6_rs_phase", int'(ph4), 0);
        cyc();
        chk("t6_rs_step", int'(ph4), 1);

        // Randomized traffic checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                start = 1'b0; stop = 1'b0;
                reset_mid("rnd_rst");
            end
            start = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 79) == 0);
            en    = ($urandom_range(0, 3) != 0);
            mode  = 2'($urandom_range(0, 3));
            dwell = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            cyc();
        end
        start = 1'b0; stop = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
